posit_encoder_param: RTL and testbench

- Parametrised, handshaked serial posit encoder.
- Takes decoded fields (sign, regime k, exponent, MSB-aligned fraction, zero/NaR flags) and assembles an N-bit posit.
- Builds the regime/exponent/fraction stream one bit per cycle, applies round-to-nearest-even with saturation, then applies two's-complement for negative values.
- Sits at the output of the posit arithmetic datapath, downstream of normalisation.

---
 rtl/posit_pkg.sv | 20 ++
 rtl/posit_round_unit.sv | 25 ++
 rtl/posit_encoder_param.sv | 146 ++++++++++++++
 tb/tb_posit_encoder_param.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: FSM states, special posit patterns and parameter legality checks for the posit encoder.
package posit_pkg;
    typedef enum logic [2:0] {IDLE, BUILD, ROUND, SIGN, DONE} state_t;

    function automatic logic [31:0] maxpos(input int n);
        return (32'h1 << (n - 1)) - 32'h1;
    endfunction

    function automatic logic [31:0] minpos(input int n);
        return 32'(n > 1);
    endfunction

    function automatic logic [31:0] nar(input int n);
        return 32'h1 << (n - 1);
    endfunction

    function automatic bit params_ok(input int n, input int es, input int kw);
        return n >= 8 && n <= 32 && es >= 0 && es <= 4 && kw >= 2 && kw <= 31 && (1 << (kw - 1)) >= n;
    endfunction
endpackage

// File: rtl/posit_round_unit.sv
// posit_round_unit: rounds and clamps the N-1 bit posit body; RNE when POSIT_ENC_RNE_EN is defined, else truncation.
module posit_round_unit
    import posit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-2:0] body_i,
    input  logic         g_i,
    input  logic         s_i,
    output logic [N-2:0] body_o
);
    logic         up;
    logic [N-2:0] r;
`ifdef POSIT_ENC_RNE_EN
    assign up = g_i & (body_i[0] | s_i) & ~&body_i;
`else
    logic unused_gs;
    assign unused_gs = g_i | s_i;
    assign up = 1'b0;
`endif
    always_comb begin
        r = body_i + (N-1)'(up);
        body_o = (r == '0) ? (N-1)'(minpos(N)) : r;
    end
endmodule

// File: rtl/posit_encoder_param.sv
// posit_encoder_param: handshaked serial posit encoder (regime/exponent/fraction build, round, sign); rounding mode via POSIT_ENC_RNE_EN.
module posit_encoder_param
    import posit_pkg::*;
#(
    parameter int N  = 32,
    parameter int ES = 2,
    parameter int MW = 32,
    parameter int KW = 6,
    localparam int EW = (ES > 0) ? ES : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sign_in,
    input  logic [KW-1:0] k_in,
    input  logic [EW-1:0] exp_in,
    input  logic [MW-1:0] frac_in,
    input  logic          zero_in,
    input  logic          nar_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  posit_out
);
    localparam int SW = N + EW + MW;
    localparam int CW = $clog2(N);

    if (!params_ok(N, ES, KW)) begin : g_bad
        $error("posit_encoder_param: illegal N/ES/KW");
    end

    state_t          state_q, state_d;
    logic            rdy_q, rdy_d, sign_q, sign_d, g_q, g_d, s_q, s_d, accept;
    logic [SW-1:0]   str_q, str_d, stream;
    logic [N-2:0]    body_q, body_d, rbody;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    posit_q, posit_d, rg;
    logic [EW+MW-1:0] ef;
    logic signed [31:0] k_s;
    logic [31:0]     rlen;

    if (ES > 0) begin : g_exp
        assign ef = {exp_in, frac_in};
    end else begin : g_noexp
        assign ef = {frac_in, 1'b0};
    end

    assign accept    = in_valid & rdy_q;
    assign in_ready  = rdy_q;
    assign out_valid = (state_q == DONE);
    assign posit_out = posit_q;

    // Left-aligned bit stream: regime of length rlen, then exponent and fraction, then zeros.
    always_comb begin
        k_s = 32'(signed'(k_in));
        rg = (k_s >= 0) ? ~({N{1'b1}} >> (k_s + 1)) : {1'b1, {(N-1){1'b0}}} >> (-k_s);
        rlen = (k_s >= 0) ? k_s + 2 : 1 - k_s;
        stream = {rg, {(EW+MW){1'b0}}} | ({{N{1'b0}}, ef} << (N - rlen));
    end

    posit_round_unit #(.N(N)) u_round (
        .body_i(body_q),
        .g_i   (g_q),
        .s_i   (s_q),
        .body_o(rbody)
    );

    always_comb begin
        state_d = state_q;
        str_d   = str_q;
        body_d  = body_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        s_d     = s_q;
        sign_d  = sign_q;
        posit_d = posit_q;
        case (state_q)
            IDLE: if (accept) begin
                sign_d = sign_in;
                if (nar_in) begin
                    posit_d = N'(nar(N));
                    state_d = DONE;
                end else if (zero_in) begin
                    posit_d = '0;
                    state_d = DONE;
                end else if (k_s >= N - 2) begin
                    body_d  = (N-1)'(maxpos(N));
                    state_d = SIGN;
                end else if (k_s <= -(N - 1)) begin
                    body_d  = (N-1)'(minpos(N));
                    state_d = SIGN;
                end else begin
                    // The accept edge already consumes the first body bit.
                    body_d  = (N-1)'(stream[SW-1]);
                    str_d   = stream << 1;
                    cnt_d   = CW'(1);
                    state_d = BUILD;
                end
            end
            BUILD: if (cnt_q == CW'(N - 1)) begin
                g_d     = str_q[SW-1];
                s_d     = |str_q[SW-2:0];
                state_d = ROUND;
            end else begin
                body_d = {body_q[N-3:0], str_q[SW-1]};
                str_d  = str_q << 1;
                cnt_d  = cnt_q + 1'b1;
            end
            ROUND: begin
                body_d  = rbody;
                state_d = SIGN;
            end
            SIGN: begin
                posit_d = sign_q ? -{1'b0, body_q} : {1'b0, body_q};
                state_d = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            str_q   <= '0;
            body_q  <= '0;
            cnt_q   <= '0;
            g_q     <= 1'b0;
            s_q     <= 1'b0;
            sign_q  <= 1'b0;
            posit_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            str_q   <= str_d;
            body_q  <= body_d;
            cnt_q   <= cnt_d;
            g_q     <= g_d;
            s_q     <= s_d;
            sign_q  <= sign_d;
            posit_q <= posit_d;
        end
    end
endmodule

// File: tb/tb_posit_encoder_param.sv
// tb_posit_encoder_param: vector table plus scoreboard for the N=32/ES=2 encoder, with an N=16/ES=1 instance.
module tb_posit_encoder_param;
    typedef struct {
        logic              s;
        logic signed [5:0] k;
        logic [1:0]        e;
        logic [31:0]       f;
        logic              z;
        logic              n;
        logic [31:0]       p;
        int                lat;
    } vec_t;

`ifdef POSIT_ENC_RNE_EN
    localparam logic [31:0] P30 = 32'h40000002, P18 = 32'h40000001, P29 = 32'h7FFFFFFF;
`else
    localparam logic [31:0] P30 = 32'h40000001, P18 = 32'h40000000, P29 = 32'h7FFFFFFE;
`endif

    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;

    logic in_valid = 1'b0, in_ready, sign_in = 1'b0, zero_in = 1'b0, nar_in = 1'b0;
    logic out_valid, out_ready = 1'b0;
    logic [5:0] k_in = '0;
    logic [1:0] exp_in = '0;
    logic [31:0] frac_in = '0, posit_out;

    logic h_in_valid = 1'b0, h_in_ready, h_sign_in = 1'b0, h_out_valid, h_out_ready = 1'b0;
    logic [5:0] h_k_in = '0;
    logic [0:0] h_exp_in = '0;
    logic [31:0] h_frac_in = '0;
    logic [15:0] h_posit_out;

    int total = 0, bad = 0;
    vec_t v[17];
    vec_t sb[$];

    posit_encoder_param #(.N(32), .ES(2), .MW(32), .KW(6)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .sign_in(sign_in),
        .k_in(k_in), .exp_in(exp_in), .frac_in(frac_in), .zero_in(zero_in), .nar_in(nar_in),
        .out_valid(out_valid), .out_ready(out_ready), .posit_out(posit_out)
    );

    posit_encoder_param #(.N(16), .ES(1), .MW(32), .KW(6)) u16 (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready), .sign_in(h_sign_in),
        .k_in(h_k_in), .exp_in(h_exp_in), .frac_in(h_frac_in), .zero_in(1'b0), .nar_in(1'b0),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .posit_out(h_posit_out)
    );

    function automatic vec_t mk(input logic s, input int k, input logic [1:0] e, input logic [31:0] f,
                                input logic z, input logic n, input logic [31:0] p, input int lat);
        vec_t x;
        x.s = s; x.k = 6'(k); x.e = e; x.f = f; x.z = z; x.n = n; x.p = p; x.lat = lat;
        return x;
    endfunction

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic drive(input vec_t x);
        sign_in = x.s; k_in = x.k; exp_in = x.e; frac_in = x.f; zero_in = x.z; nar_in = x.n;
        in_valid = 1'b1;
    endtask

    task automatic run(input vec_t x, input int hold);
        int c;
        vec_t e;
        c = 0;
        while (!in_ready && c < 200) begin @(negedge clk); c++; end
        chk("in_ready_idle", in_ready, 1);
        drive(x);
        sb.push_back(x);
        @(negedge clk);
        in_valid = 1'b0;
        c = 1;
        while (!out_valid && c < 200) begin @(negedge clk); c++; end
        e = sb.pop_front();
        chk("posit", posit_out, e.p);
        chk("latency", c, e.lat);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; nar_in = 1'b1;
            @(negedge clk);
            chk("bp_stable", posit_out, e.p);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
        end
        in_valid = 1'b0; nar_in = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_back", in_ready, 1);
    endtask

    task automatic run16(input logic s, input int k, input logic [15:0] p, input int lat);
        int c;
        c = 0;
        while (!h_in_ready && c < 200) begin @(negedge clk); c++; end
        h_sign_in = s; h_k_in = 6'(k); h_exp_in = '0; h_frac_in = '0; h_in_valid = 1'b1;
        @(negedge clk);
        h_in_valid = 1'b0;
        c = 1;
        while (!h_out_valid && c < 200) begin @(negedge clk); c++; end
        chk("n16_posit", h_posit_out, p);
        chk("n16_latency", c, lat);
        h_out_ready = 1'b1;
        @(negedge clk);
        h_out_ready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0]  = mk(0,   0, 2'd0, 32'h00000000, 0, 0, 32'h40000000, 34);
        v[1]  = mk(1,   0, 2'd0, 32'h00000000, 0, 0, 32'hC0000000, 34);
        v[2]  = mk(0,  -1, 2'd0, 32'h00000000, 0, 0, 32'h20000000, 34);
        v[3]  = mk(0,   1, 2'd0, 32'h00000000, 0, 0, 32'h60000000, 34);
        v[4]  = mk(0,   0, 2'd0, 32'h00000010, 0, 0, 32'h40000000, 34);
        v[5]  = mk(0,   0, 2'd0, 32'h00000030, 0, 0, P30, 34);
        v[6]  = mk(0,   0, 2'd0, 32'h00000018, 0, 0, P18, 34);
        v[7]  = mk(0,  30, 2'd0, 32'h00000000, 0, 0, 32'h7FFFFFFF, 2);
        v[8]  = mk(1,  30, 2'd0, 32'h00000000, 0, 0, 32'h80000001, 2);
        v[9]  = mk(0, -31, 2'd0, 32'h00000000, 0, 0, 32'h00000001, 2);
        v[10] = mk(0, -30, 2'd0, 32'hFFFFFFFF, 0, 0, 32'h00000001, 34);
        v[11] = mk(0,   5, 2'd1, 32'h12345678, 0, 1, 32'h80000000, 1);
        v[12] = mk(1,   3, 2'd2, 32'h87654321, 1, 0, 32'h00000000, 1);
        v[13] = mk(0,   0, 2'd0, 32'h00000000, 1, 1, 32'h80000000, 1);
        v[14] = mk(1,   2, 2'd3, 32'hA0000000, 0, 0, 32'h88C00000, 34);
        v[15] = mk(0,  -3, 2'd1, 32'h80000000, 0, 0, 32'h0B000000, 34);
        v[16] = mk(0,  29, 2'd3, 32'h00000000, 0, 0, P29, 34);

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_posit", posit_out, 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", in_ready, 0);
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        for (int i = 0; i < 17; i++) run(v[i], 0);

        run(v[3], 5);
        run(v[15], 0);

        drive(v[1]);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_posit", posit_out, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle_ready", in_ready, 1);
        chk("abort_no_output", out_valid, 0);
        run(v[0], 0);

        run16(0, 0, 16'h4000, 18);
        run16(1, 0, 16'hC000, 18);
        run16(0, 14, 16'h7FFF, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
